// File: rtl/mc_controller_if.sv
// Bus between the multicycle controller and its datapath: instruction
// fields and ALU flags in, control strobes and the debug state out.
interface mc_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       pc_wr;
    logic       ir_wr;
    logic       regwrite;
    logic       memwrite;
    logic [2:0] aluop;
    logic       alusrc;
    logic       ext_sel;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] npc_sel;
    logic       of_control;
    logic       lb_flag;
    logic [3:0] state;

    // Datapath side
    modport master (
        output opcode, funct, zero, overflow,
        input  pc_wr, ir_wr, regwrite, memwrite, aluop, alusrc, ext_sel,
               regdst, memtoreg, npc_sel, of_control, lb_flag, state
    );

    // Controller side
    modport slave (
        input  opcode, funct, zero, overflow,
        output pc_wr, ir_wr, regwrite, memwrite, aluop, alusrc, ext_sel,
               regdst, memtoreg, npc_sel, of_control, lb_flag, state
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset controller. Only the state register is sequential;
// every control output is a combinational decode of state and opcode/funct.
//
// state  | meaning
// FETCH  | load IR, PC <= PC+4
// DECODE | classify instruction
// MEMADR | compute base+offset
// MEMRD  | data memory read, address held
// MEMWB  | write loaded data to rt
// MEMWR  | store to data memory
// EXEC   | ALU operation
// ALUWB  | write ALU result (rd for R-type, rt otherwise)
// BRANCH | beq compare, conditional PC load
// JUMP   | j / jal / jr PC load
module mc_controller (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.slave  bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_LUI = 3'b100;

    state_t state, next_state;

    logic is_rtype, is_lw, is_lb, is_sw, is_addi, is_addiu, is_ori, is_lui;
    logic is_addu, is_subu, is_slt, is_beq, is_j, is_jal, is_jr, is_alu;
    logic [2:0] alu_op;
    logic       alu_src, alu_ext, alu_of;

    // Instruction classification from the live IR fields
    always_comb begin
        is_rtype = (bus.opcode == 6'b000000);
        is_lw    = (bus.opcode == 6'b100011);
        is_lb    = (bus.opcode == 6'b100000);
        is_sw    = (bus.opcode == 6'b101011);
        is_addi  = (bus.opcode == 6'b001000);
        is_addiu = (bus.opcode == 6'b001001);
        is_ori   = (bus.opcode == 6'b001101);
        is_lui   = (bus.opcode == 6'b001111);
        is_beq   = (bus.opcode == 6'b000100);
        is_j     = (bus.opcode == 6'b000010);
        is_jal   = (bus.opcode == 6'b000011);
        is_addu  = is_rtype && (bus.funct == 6'b100001);
        is_subu  = is_rtype && (bus.funct == 6'b100011);
        is_slt   = is_rtype && (bus.funct == 6'b101010);
        is_jr    = is_rtype && (bus.funct == 6'b001000);
        is_alu   = is_addi || is_addiu || is_ori || is_lui || is_addu || is_subu || is_slt;
    end

    // ALU decode shared by EXEC and ALUWB so the result stays stable for writeback
    always_comb begin
        alu_op  = ALU_ADD;
        alu_src = 1'b0;
        alu_ext = 1'b1;
        alu_of  = 1'b0;
        if (is_addi) begin
            alu_src = 1'b1;
            alu_of  = 1'b1;
        end else if (is_addiu) begin
            alu_src = 1'b1;
        end else if (is_ori) begin
            alu_op  = ALU_OR;
            alu_src = 1'b1;
            alu_ext = 1'b0;
        end else if (is_lui) begin
            alu_op  = ALU_LUI;
            alu_src = 1'b1;
        end else if (is_subu) begin
            alu_op  = ALU_SUB;
        end else if (is_slt) begin
            alu_op  = ALU_SLT;
            alu_src = 1'b1;
        end
    end

    // State register; reset wins from any state, including mid-instruction
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // Next-state and control decode; during reset the FETCH decode is shown
    // with the PC/IR strobes suppressed so nothing is written
    always_comb begin
        state_t cur;
        cur            = reset ? S_FETCH : state;
        next_state     = S_FETCH;
        bus.pc_wr      = 1'b0;
        bus.ir_wr      = 1'b0;
        bus.regwrite   = 1'b0;
        bus.memwrite   = 1'b0;
        bus.aluop      = ALU_ADD;
        bus.alusrc     = 1'b0;
        bus.ext_sel    = 1'b1;
        bus.regdst     = 2'b00;
        bus.memtoreg   = 2'b00;
        bus.npc_sel    = 2'b00;
        bus.of_control = 1'b0;
        bus.lb_flag    = 1'b0;
        case (cur)
            S_FETCH: begin
                bus.pc_wr  = 1'b1;
                bus.ir_wr  = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                if (is_lw || is_lb || is_sw) next_state = S_MEMADR;
                else if (is_alu)             next_state = S_EXEC;
                else if (is_beq)             next_state = S_BRANCH;
                else if (is_j || is_jal || is_jr) next_state = S_JUMP;
            end
            S_MEMADR: begin
                bus.alusrc = 1'b1;
                if (is_lw || is_lb) next_state = S_MEMRD;
                else if (is_sw)     next_state = S_MEMWR;
            end
            S_MEMRD: begin
                bus.alusrc  = 1'b1;
                bus.lb_flag = is_lb;
                next_state  = S_MEMWB;
            end
            S_MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 2'b01;
                bus.lb_flag  = is_lb;
            end
            S_MEMWR: begin
                bus.memwrite = 1'b1;
                bus.alusrc   = 1'b1;
            end
            S_EXEC: begin
                bus.aluop      = alu_op;
                bus.alusrc     = alu_src;
                bus.ext_sel    = alu_ext;
                bus.of_control = alu_of;
                next_state     = S_ALUWB;
            end
            S_ALUWB: begin
                bus.aluop      = alu_op;
                bus.alusrc     = alu_src;
                bus.ext_sel    = alu_ext;
                bus.of_control = alu_of;
                bus.regwrite   = !(is_addi && bus.overflow);
                bus.regdst     = is_rtype ? 2'b01 : 2'b00;
            end
            S_BRANCH: begin
                bus.aluop   = ALU_SUB;
                bus.npc_sel = 2'b01;
                bus.pc_wr   = bus.zero;
            end
            S_JUMP: begin
                bus.pc_wr   = 1'b1;
                bus.npc_sel = is_jr ? 2'b11 : 2'b10;
                if (is_jal) begin
                    bus.regwrite = 1'b1;
                    bus.regdst   = 2'b10;
                    bus.memtoreg = 2'b10;
                end
            end
            default: next_state = S_FETCH;
        endcase
        if (reset) begin
            bus.pc_wr = 1'b0;
            bus.ir_wr = 1'b0;
        end
    end

    assign bus.state = state;
endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instruction runs, random instruction
// streams and mid-instruction resets against an instruction-level model.
module tb_mc_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_controller_if bus();
    mc_controller dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum int {
        C_LW, C_LB, C_SW, C_ADDI, C_ADDIU, C_ORI, C_LUI, C_ADDU, C_SUBU,
        C_SLT, C_BEQ, C_J, C_JAL, C_JR, C_NOP
    } cls_t;

    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b100011: return C_LW;
            6'b100000: return C_LB;
            6'b101011: return C_SW;
            6'b001000: return C_ADDI;
            6'b001001: return C_ADDIU;
            6'b001101: return C_ORI;
            6'b001111: return C_LUI;
            6'b000100: return C_BEQ;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            6'b000000: begin
                case (fn)
                    6'b100001: return C_ADDU;
                    6'b100011: return C_SUBU;
                    6'b101010: return C_SLT;
                    6'b001000: return C_JR;
                    default:   return C_NOP;
                endcase
            end
            default: return C_NOP;
        endcase
    endfunction

    function automatic bit is_alu_cls(input cls_t c);
        return c inside {C_ADDI, C_ADDIU, C_ORI, C_LUI, C_ADDU, C_SUBU, C_SLT};
    endfunction

    // Visited states, in order, for one instruction
    function automatic void build_path(input cls_t c, output int path[$]);
        path = {0, 1};
        if (c == C_LW || c == C_LB) path = {path, 2, 3, 4};
        else if (c == C_SW)         path = {path, 2, 5};
        else if (is_alu_cls(c))     path = {path, 6, 7};
        else if (c == C_BEQ)        path = {path, 8};
        else if (c inside {C_J, C_JAL, C_JR}) path = {path, 9};
    endfunction

    function automatic logic [16:0] pack(
        input logic pc, ir, rw, mw, input logic [2:0] aop, input logic asrc, ext,
        input logic [1:0] rdst, m2r, npc, input logic of, lb);
        return {pc, ir, rw, mw, aop, asrc, ext, rdst, m2r, npc, of, lb};
    endfunction

    function automatic logic [16:0] actual_vec();
        return pack(bus.pc_wr, bus.ir_wr, bus.regwrite, bus.memwrite, bus.aluop,
                    bus.alusrc, bus.ext_sel, bus.regdst, bus.memtoreg, bus.npc_sel,
                    bus.of_control, bus.lb_flag);
    endfunction

    // Expected control word for instruction class c while in state st
    function automatic void expect_cycle(input cls_t c, input int st, input logic z,
                                         input logic ov, output logic [16:0] v,
                                         output logic [16:0] m);
        logic pc = 0, ir = 0, rw = 0, mw = 0, asrc = 0, ext = 1, of = 0, lb = 0;
        logic [2:0] aop = 3'b000;
        logic [1:0] rdst = 2'b00, m2r = 2'b00, npc = 2'b00;
        m = '1;
        if (st == 6 || st == 7) begin
            case (c)
                C_ADDI:  begin asrc = 1; of = 1; end
                C_ADDIU: asrc = 1;
                C_ORI:   begin aop = 3'b001; asrc = 1; ext = 0; end
                C_LUI:   begin aop = 3'b100; asrc = 1; end
                C_SUBU:  aop = 3'b011;
                C_SLT:   begin aop = 3'b010; asrc = 1; end
                default: ;
            endcase
        end
        case (st)
            0: begin pc = 1; ir = 1; end
            2: asrc = 1;
            3: begin
                lb = (c == C_LB);
                m  = pack(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
            end
            4: begin
                rw = 1; m2r = 2'b01; lb = (c == C_LB);
                m  = pack(1, 1, 1, 1, 0, 0, 0, 2'b11, 2'b11, 0, 0, 1);
            end
            5: begin mw = 1; asrc = 1; end
            7: begin
                rw   = !(c == C_ADDI && ov);
                rdst = (c inside {C_ADDU, C_SUBU, C_SLT}) ? 2'b01 : 2'b00;
            end
            8: begin aop = 3'b011; npc = 2'b01; pc = z; end
            9: begin
                pc  = 1;
                npc = (c == C_JR) ? 2'b11 : 2'b10;
                if (c == C_JAL) begin rw = 1; rdst = 2'b10; m2r = 2'b10; end
            end
            default: ;
        endcase
        v = pack(pc, ir, rw, mw, aop, asrc, ext, rdst, m2r, npc, of, lb);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Runs one instruction starting just after the edge that entered FETCH
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic ov, input string tag);
        cls_t c;
        int path[$];
        logic [16:0] v, m, a;
        c = classify(op, fn);
        build_path(c, path);
        bus.opcode = op; bus.funct = fn; bus.zero = z; bus.overflow = ov;
        foreach (path[i]) begin
            @(negedge clk);
            expect_cycle(c, path[i], z, ov, v, m);
            a = actual_vec();
            n_checks++;
            if (bus.state !== path[i][3:0]) begin
                n_fail++;
                $display("FAIL %s state step %0d: got %0d expected %0d", tag, i, bus.state, path[i]);
            end
            n_checks++;
            if ((a & m) !== (v & m)) begin
                n_fail++;
                $display("FAIL %s ctrl step %0d st %0d: got %05h expected %05h (mask %05h)",
                         tag, i, path[i], a, v, m);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [16:0] rv;
        rv = pack(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        reset = 1'b1;
        bus.opcode = 6'b100011; bus.funct = 6'd0; bus.zero = 1'b1; bus.overflow = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.state !== 4'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state);
        end
        n_checks++;
        if (actual_vec() !== rv) begin
            n_fail++; $display("FAIL reset_ctrl: got %05h expected %05h", actual_vec(), rv);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.state !== 4'd0 || bus.pc_wr !== 1'b1 || bus.ir_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got state %0d pc_wr %b ir_wr %b expected 0 1 1",
                     bus.state, bus.pc_wr, bus.ir_wr);
        end
        do_reset();
    endtask

    task automatic test_memory();
        run_instr(6'b100011, 6'h00, 0, 0, "lw");
        run_instr(6'b100000, 6'h15, 1, 0, "lb");
        run_instr(6'b101011, 6'h2a, 0, 1, "sw");
    endtask

    task automatic test_branch();
        run_instr(6'b000100, 6'h00, 1, 0, "beq_taken");
        run_instr(6'b000100, 6'h00, 0, 0, "beq_not_taken");
    endtask

    task automatic test_jumps();
        run_instr(6'b000010, 6'h08, 0, 0, "j");
        run_instr(6'b000011, 6'h00, 1, 0, "jal");
        run_instr(6'b000000, 6'b001000, 0, 0, "jr");
    endtask

    task automatic test_addi_overflow();
        run_instr(6'b001000, 6'h00, 0, 1, "addi_ovf");
        run_instr(6'b001000, 6'h00, 0, 0, "addi_no_ovf");
    endtask

    task automatic test_alu_ops();
        run_instr(6'b001001, 6'h00, 0, 1, "addiu");
        run_instr(6'b001101, 6'h00, 0, 0, "ori");
        run_instr(6'b001111, 6'h00, 1, 0, "lui");
        run_instr(6'b000000, 6'b100001, 0, 1, "addu");
        run_instr(6'b000000, 6'b100011, 0, 0, "subu");
        run_instr(6'b000000, 6'b101010, 0, 0, "slt");
    endtask

    task automatic test_unsupported();
        run_instr(6'b111111, 6'h00, 0, 0, "op_3f");
        run_instr(6'b000000, 6'b100000, 0, 0, "rtype_add");
    endtask

    // Walks an instruction to the target state, then resets in that cycle
    task automatic test_reset_mid(input logic [5:0] op, input logic [5:0] fn,
                                  input int edges, input logic [3:0] target, input string tag);
        logic [16:0] rv;
        rv = pack(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        bus.opcode = op; bus.funct = fn; bus.zero = 0; bus.overflow = 0;
        repeat (edges) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.state !== target) begin
            n_fail++; $display("FAIL %s pre_state: got %0d expected %0d", tag, bus.state, target);
        end
        n_checks++;
        if (actual_vec() !== rv) begin
            n_fail++; $display("FAIL %s ctrl_in_reset: got %05h expected %05h", tag, actual_vec(), rv);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.state !== 4'd0 || bus.pc_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL %s post_reset: got state %0d pc_wr %b expected 0 1", tag, bus.state, bus.pc_wr);
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        logic [11:0] menu [16];
        menu = '{ {6'o43, 6'o00}, {6'o40, 6'o00}, {6'o53, 6'o00}, {6'o10, 6'o00},
                  {6'o11, 6'o00}, {6'o15, 6'o00}, {6'o17, 6'o00}, {6'o00, 6'o41},
                  {6'o00, 6'o43}, {6'o00, 6'o52}, {6'o04, 6'o00}, {6'o02, 6'o00},
                  {6'o03, 6'o00}, {6'o00, 6'o10}, {6'o77, 6'o00}, {6'o00, 6'o00} };
        for (int k = 0; k < 80; k++) begin
            logic [11:0] sel;
            logic [5:0] op, fn;
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                sel = menu[$urandom_range(0, 15)];
                op  = sel[11:6];
                fn  = sel[5:0];
            end
            run_instr(op, fn, 1'($urandom), 1'($urandom), $sformatf("rnd%0d", k));
        end
        @(negedge clk);
        n_checks++;
        if (bus.state !== 4'd0) begin
            n_fail++; $display("FAIL rnd_final_state: got %0d expected 0", bus.state);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.overflow = 1'b0;
        test_reset();
        test_memory();
        test_branch();
        test_jumps();
        test_addi_overflow();
        test_alu_ops();
        test_unsupported();
        test_reset_mid(6'b101011, 6'h00, 3, 4'd5, "rst_in_memwr");
        test_reset_mid(6'b000000, 6'b100001, 3, 4'd7, "rst_in_aluwb");
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
